// File: rtl/led_seq_pkg.sv
// ------------------------------------------------------------------
// led_seq_pkg: mode encoding and default parameters  (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam int DEF_NUM_LEDS     = 8;
  localparam int DEF_CLK_HZ       = 50_000_000;
  localparam int DEF_STEP_HZ      = 4;
  localparam int DEF_PWM_BITS     = 8;
  localparam int DEF_READY_CYCLES = 512;

  // Wide alternating word; truncated to NUM_LEDS bits for the idle pattern.
  localparam logic [63:0] DEF_IDLE_WORD = 64'hAAAA_AAAA_AAAA_AAAA;

endpackage

`default_nettype wire

// File: rtl/cclk_detector.sv
// ------------------------------------------------------------------
// cclk_detector: synchronises cclk and qualifies it as AVR ready  (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module cclk_detector
  import led_seq_pkg::*;
#(
  parameter int READY_CYCLES = DEF_READY_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cclk,
  output logic avr_ready
);

  localparam int              CNT_W     = $clog2(READY_CYCLES + 1);
  localparam logic [CNT_W-1:0] READY_VAL = CNT_W'(READY_CYCLES);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] qual_cnt;
  logic [CNT_W-1:0] qual_cnt_next;

  always_comb begin
    qual_cnt_next = qual_cnt;
    if (!sync_q[1]) begin
      qual_cnt_next = '0;
    end else if (qual_cnt != READY_VAL) begin
      qual_cnt_next = qual_cnt + 1'b1;
    end
  end

  // avr_ready is registered from the next count so it always equals (count == READY).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      qual_cnt  <= '0;
      avr_ready <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], cclk};
      qual_cnt  <= qual_cnt_next;
      avr_ready <= (qual_cnt_next == READY_VAL);
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_sequencer.sv
// ------------------------------------------------------------------
// led_sequencer: static/blink/chase/breathe LED pattern driver  (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int                    NUM_LEDS     = DEF_NUM_LEDS,
  parameter int                    CLK_HZ       = DEF_CLK_HZ,
  parameter int                    STEP_HZ      = DEF_STEP_HZ,
  parameter int                    PWM_BITS     = DEF_PWM_BITS,
  parameter int                    READY_CYCLES = DEF_READY_CYCLES,
  parameter logic [NUM_LEDS-1:0]   IDLE_PATTERN = NUM_LEDS'(DEF_IDLE_WORD)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cclk,
  input  logic [1:0]          mode,
  input  logic [NUM_LEDS-1:0] pattern,
  input  logic                load,
  output logic [NUM_LEDS-1:0] led,
  output logic                avr_ready,
  output logic                step_tick
);

  localparam int                  DIV        = CLK_HZ / STEP_HZ;
  localparam int                  PRE_W      = $clog2(DIV);
  localparam logic [PRE_W-1:0]    PRESC_LAST = PRE_W'(DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
  localparam logic [PWM_BITS-1:0] DUTY_TURN  = DUTY_MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE   = PWM_BITS'(1);

  logic [PRE_W-1:0]    presc;
  mode_e               mode_r;
  logic [NUM_LEDS-1:0] pat_r;
  logic [NUM_LEDS-1:0] chase;
  logic                phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic                duty_down;
  logic                pwm_wrap;
  logic [NUM_LEDS-1:0] led_sel;

  cclk_detector #(
    .READY_CYCLES (READY_CYCLES)
  ) u_cclk_detector (
    .clk       (clk),
    .rst_n     (rst_n),
    .cclk      (cclk),
    .avr_ready (avr_ready)
  );

  assign step_tick = (presc == PRESC_LAST);
  assign pwm_wrap  = (pwm_cnt == DUTY_MAX);

  always_comb begin
    led_sel = pat_r;
    case (mode_r)
      MODE_STATIC:  led_sel = pat_r;
      MODE_BLINK:   led_sel = phase ? pat_r : '0;
      MODE_CHASE:   led_sel = chase;
      MODE_BREATHE: led_sel = pat_r & {NUM_LEDS{pwm_cnt < duty}};
      default:      led_sel = pat_r;
    endcase
  end

  // All mode state advances every step regardless of mode or readiness;
  // a load in the same cycle as step_tick discards that step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      mode_r    <= MODE_STATIC;
      pat_r     <= '0;
      chase     <= '0;
      phase     <= 1'b0;
      pwm_cnt   <= '0;
      duty      <= '0;
      duty_down <= 1'b0;
      led       <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (load) begin
        mode_r    <= mode_e'(mode);
        pat_r     <= pattern;
        presc     <= '0;
        phase     <= 1'b0;
        duty      <= '0;
        duty_down <= 1'b0;
        chase     <= (pattern == '0) ? {{(NUM_LEDS-1){1'b0}}, 1'b1} : pattern;
      end else begin
        presc <= step_tick ? '0 : presc + 1'b1;
        if (step_tick) begin
          phase <= ~phase;
          chase <= {chase[NUM_LEDS-2:0], chase[NUM_LEDS-1]};
        end
        if (pwm_wrap) begin
          if (!duty_down) begin
            duty <= duty + 1'b1;
            if (duty == DUTY_TURN) duty_down <= 1'b1;
          end else begin
            duty <= duty - 1'b1;
            if (duty == DUTY_ONE) duty_down <= 1'b0;
          end
        end
      end
      led <= avr_ready ? led_sel : IDLE_PATTERN;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
// ------------------------------------------------------------------
// tb_led_sequencer: scoreboard bench for led_sequencer  (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cclk = 1'b0;
  logic       load = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] pattern = 8'h00;
  logic [7:0] led;
  logic       avr_ready;
  logic       step_tick;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_evt = -1;

  logic [7:0] exp_q[$];
  int         pwm_q[$];
  logic       breathe_on = 1'b0;
  int         breathe_start = 0;
  int         hi_cnt = 0;
  int         mixed = 0;

  always #5 clk = ~clk;

  led_sequencer #(
    .NUM_LEDS     (8),
    .CLK_HZ       (100),
    .STEP_HZ      (10),
    .PWM_BITS     (3),
    .READY_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cclk      (cclk),
    .mode      (mode),
    .pattern   (pattern),
    .load      (load),
    .led       (led),
    .avr_ready (avr_ready),
    .step_tick (step_tick)
  );

  // Edge index since reset release; after edge k the PWM counter equals k mod 8.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Step monitor: tick spacing and per-step LED value from the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_evt = -1;
    end else if (load) begin
      last_evt = cyc;
    end else if (step_tick) begin
      check("tick_gap", cyc - last_evt, 10);
      last_evt = cyc;
      if (exp_q.size() > 0) check("led_step", led, exp_q.pop_front());
    end
  end

  // Breathe monitor: count high LED cycles per aligned 8-cycle PWM period.
  always @(negedge clk) begin
    if (breathe_on && rst_n && cyc > breathe_start) begin
      if (led == 8'hFF)      hi_cnt++;
      else if (led != 8'h00) mixed++;
      if ((cyc - breathe_start) % 8 == 0) begin
        if (pwm_q.size() > 0) begin
          check("breathe_high", hi_cnt, pwm_q.pop_front());
          check("breathe_mixed", mixed, 0);
        end
        hi_cnt = 0;
        mixed  = 0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] m, input logic [7:0] p);
    load = 1'b1; mode = m; pattern = p;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!avr_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    rst_n = 1'b0; cclk = 1'b1;
    cycles(3);
    check("rst_led", led, 8'h00);
    check("rst_ready", avr_ready, 1'b0);
    check("rst_tick", step_tick, 1'b0);

    // Ready qualification with idle pattern before it
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!avr_ready) check("idle_led", led, 8'hAA);
    end while (!avr_ready && n < 40);
    check("ready_latency_18_19", (n >= 18 && n <= 19), 1'b1);
    cycles(2);
    check("static_after_ready", led, 8'h00);

    // One-cycle cclk glitch
    cclk = 1'b0;
    cycles(1);
    cclk = 1'b1;
    n = 0;
    while (avr_ready && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    check("glitch_drop", avr_ready, 1'b0);
    wait_ready(n);
    check("requalify_cycles", n, 16);
    cycles(2);

    // CHASE with wrap of bit 7 into bit 0
    exp_q.push_back(8'h81); exp_q.push_back(8'h03); exp_q.push_back(8'h06);
    do_load(2'd2, 8'h81);
    drain("chase81_done", 60);

    // CHASE from zero pattern walks a single bit
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(1 << i));
    exp_q.push_back(8'h01);
    do_load(2'd2, 8'h00);
    drain("chase0_done", 120);

    // STATIC
    exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
    do_load(2'd0, 8'h5A);
    drain("static_done", 40);

    // BLINK loaded in the same cycle as step_tick
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!step_tick && n < 20);
    check("found_tick", step_tick, 1'b1);
    exp_q.push_back(8'h00); exp_q.push_back(8'hF0);
    exp_q.push_back(8'h00); exp_q.push_back(8'hF0);
    do_load(2'd1, 8'hF0);
    drain("blink_done", 60);

    // BREATHE: load lands on edge index = 4 mod 8, first full period has duty 1
    n = 0;
    while (cyc % 8 != 3 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    do_load(2'd3, 8'hFF);
    breathe_start = cyc + 4;
    for (int d = 1; d <= 7; d++) pwm_q.push_back(d);
    for (int d = 6; d >= 0; d--) pwm_q.push_back(d);
    pwm_q.push_back(1); pwm_q.push_back(2);
    hi_cnt = 0; mixed = 0;
    breathe_on = 1'b1;
    n = 0;
    while (pwm_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    breathe_on = 1'b0;
    check("breathe_done", pwm_q.size(), 0);
    pwm_q.delete();

    // Reset in the middle of a chase
    do_load(2'd2, 8'h81);
    cycles(25);
    rst_n = 1'b0;
    #1;
    check("midrst_led", led, 8'h00);
    check("midrst_ready", avr_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_tick", step_tick, 1'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(1);
    check("midrst_idle", led, 8'hAA);
    wait_ready(n);
    check("midrst_requal", (n >= 17 && n <= 18), 1'b1);
    cycles(2);
    check("midrst_static0", led, 8'h00);
    exp_q.push_back(8'h00);
    drain("midrst_step_done", 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter NUM_LEDS, default 8, number of LED outputs, minimum 2.
REQ-002 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-003 Parameter STEP_HZ, default 4, pattern step rate; DIV = CLK_HZ/STEP_HZ, integer division, at least 2.
REQ-004 Parameter PWM_BITS, default 8, PWM counter and duty width.
REQ-005 Parameter READY_CYCLES, default 512, consecutive cclk-high cycles required before the AVR is treated as ready.
REQ-006 Parameter IDLE_PATTERN, default alternating 1010..., NUM_LEDS bits, LED value shown while the AVR is not ready.
REQ-007 clk  in  1  system clock; the block has one clock.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 cclk  in  1  AVR ready indication, asynchronous to clk.
REQ-010 mode  in  2  requested mode, sampled only on load.
REQ-011 pattern  in  NUM_LEDS  requested pattern, sampled only on load.
REQ-012 load  in  1  single-cycle capture strobe.
REQ-013 led  out  NUM_LEDS  registered LED drive.
REQ-014 avr_ready  out  1  registered, high once cclk qualification is complete.
REQ-015 step_tick  out  1  one-cycle pulse at each prescaler wrap.

Function
REQ-016 cclk passes through a two-flop synchroniser; the qualification counter increments while the synchronised cclk is 1, saturates at READY_CYCLES, and clears in the same cycle the synchronised cclk reads 0.
REQ-017 avr_ready is 1 exactly when the counter equals READY_CYCLES; a single low sample on cclk deasserts it on the next clock.
REQ-018 Prescaler counts 0..DIV-1 and wraps to 0; step_tick is 1 in the cycle where the count equals DIV-1.
REQ-019 On load=1: mode_r and pat_r capture the inputs; the prescaler, blink phase, and duty clear to 0; the duty direction is set to up; the chase register loads pattern, or bit 0 only if pattern is 0.
REQ-020 If load and step_tick coincide, load wins and that step is discarded.
REQ-021 Mode 0 STATIC: led = pat_r.
REQ-022 Mode 1 BLINK: phase toggles on each step_tick; led = pat_r when phase is 1, otherwise 0; phase is 0 after load, so the LEDs are dark for the first step period.
REQ-023 Mode 2 CHASE: on each step_tick the chase register rotates left by 1, with bit NUM_LEDS-1 wrapping to bit 0; led = chase register.
REQ-024 Mode 3 BREATHE: a free-running PWM_BITS counter runs continuously; at each counter wrap, duty steps by 1 toward the current direction.
REQ-025 BREATHE direction reverses on reaching the all-ones duty value or 0, giving a triangle waveform with no repeated endpoint value.
REQ-026 BREATHE output: led = pat_r AND (pwm_cnt < duty) for every bit; duty 0 gives fully off.
REQ-027 While avr_ready = 0, led = IDLE_PATTERN regardless of mode.
REQ-028 While avr_ready = 0, the mode state keeps advancing.
REQ-029 led is registered, one cycle after the selecting state changes.
REQ-030 load is honoured whether or not avr_ready is 1.

Reset
REQ-031 rst_n low asynchronously clears all registers: led = 0, avr_ready = 0, step_tick = 0, and the counters, phase, and duty = 0.
REQ-032 After reset: mode_r = STATIC, pat_r = 0, chase register = 0.
REQ-033 In the first clock after release, led = IDLE_PATTERN.
REQ-034 Reset asserted mid-operation (for example mid-chase or with duty high) abandons state immediately; no step_tick is emitted during reset.

Structure
REQ-035 Shared package led_seq_pkg holds the mode constants (MODE_STATIC = 0, MODE_BLINK = 1, MODE_CHASE = 2, MODE_BREATHE = 3) and the default parameter values.
REQ-036 Sub-module cclk_detector contains the synchroniser and qualification counter (REQ-016, REQ-017), is parametrised by READY_CYCLES, and outputs avr_ready.

Verification
REQ-037 All scenarios use NUM_LEDS=8, CLK_HZ=100, STEP_HZ=10, READY_CYCLES=16, PWM_BITS=3.
REQ-038 Ready qualification: cclk=1 from reset release -> avr_ready rises 18-19 cycles later, with led = 0xAA before that; a 1-cycle cclk glitch low -> avr_ready drops, then re-qualifies after a further 16 high cycles.
REQ-039 CHASE wrap: load mode 2 with pattern 0x81 -> led sequence 0x81, 0x03, 0x06 over successive steps spaced 10 cycles; load with pattern 0 -> 0x01, 0x02, ..., 0x80, 0x01.
REQ-040 Collision: load with mode 1 and pattern 0xF0 issued in the same cycle as step_tick -> the next step_tick follows 10 cycles later; led stays 0x00 for one step period, then alternates 0xF0/0x00 with 10 cycles per state.
REQ-041 BREATHE: load mode 3 with pattern 0xFF -> duty sequence 0,1,...,7,6,...,0,1 with one step per 8 cycles; the per-PWM-period high count on each LED equals duty.
REQ-042 Reset mid-chase: rst_n low for 3 cycles mid-run -> led = 0 asynchronously, then 0xAA until re-qualification, with mode = STATIC and pattern = 0.
